lcd_bus_driver: RTL
===================

Name: lcd_bus_driver

Overview:
- Peripheral-side end of the LCD memory-mapped register: consumes CPU stores to the LCD window (0x7030–0x703F) and turns each into one timed HD44780-style write cycle on the board's 8-bit LCD bus.
- Generates setup, enable pulse, hold and command-execution waits in hardware.
- Returns a status word that the load path maps back into the LCD window, so software polls busy instead of bit-banging timing.

Parameters:
- SETUP_CYC, 3, cycles RS/DATA are stable before EN rises (tAS).
- EN_CYC, 25, cycles EN is held high (PWEH).
- HOLD_CYC, 3, cycles RS/DATA are held after EN falls (tH).
- EXEC_CYC, 2500, execution wait for normal commands and data writes (50 us at 50 MHz).
- LONG_EXEC_CYC, 82000, execution wait for clear/home commands (1.64 ms at 50 MHz).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- lcd_we  input  1  one-cycle store strobe for the LCD address window.
- lcd_wdata  input  32  store data.
  - [31] ON.
  - [30] CTRL_ONLY.
  - [9] RS.
  - [7:0] DATA.
  - All other bits ignored.
- lcd_status  output  32  status word.
  - [0] busy.
  - [1] overrun.
  - [2] on.
  - [31:3] zero.
- lcd_data  output  8  LCD data bus.
- lcd_rs  output  1  register select.
- lcd_rw  output  1  read/write; tied to 0, write-only.
- lcd_en  output  1  enable strobe.
- lcd_on  output  1  LCD power.

Behaviour:
- Reset (asynchronous, immediate, also mid-transaction):
  - State = IDLE, all counters 0.
  - lcd_en, lcd_rs, lcd_data, lcd_on, busy and overrun = 0.
  - lcd_rw is always 0.
- States: IDLE, SETUP, ENABLE, HOLD, EXEC. One down-counter, width sized for the largest of the parameters.
- Acceptance: a normal write (lcd_we=1, lcd_wdata[30]=0) is accepted only when state==IDLE in that cycle.
- On acceptance, at the next edge:
  - Latch RS and DATA onto lcd_rs/lcd_data.
  - lcd_on <= lcd_wdata[31].
  - State -> SETUP, busy=1.
- SETUP lasts SETUP_CYC cycles, then ENABLE.
- ENABLE: lcd_en=1 for exactly EN_CYC cycles, then HOLD with lcd_en=0.
- HOLD lasts HOLD_CYC cycles, then EXEC.
- EXEC wait length:
  - LONG_EXEC_CYC if RS=0 and DATA[7:2]==0 and DATA!=0 (clear 0x01, home 0x02/0x03).
  - EXEC_CYC otherwise.
  - After the wait, state -> IDLE and busy=0.
- lcd_rs/lcd_data hold their latched values from SETUP through IDLE until the next accepted write.
- busy timing: the first busy-high cycle is the cycle after the strobe. Total busy cycles = SETUP_CYC+EN_CYC+HOLD_CYC+wait. busy is registered and equals (state!=IDLE).
- Write at the IDLE boundary: a strobe in the first IDLE cycle (busy=0) is accepted; a strobe in the last EXEC cycle is not.
- Normal write while state!=IDLE:
  - Dropped; bus and lcd_on are unchanged.
  - overrun <= 1 (sticky).
- Control-only write (lcd_we=1, lcd_wdata[30]=1):
  - Accepted in any state.
  - lcd_on <= [31] and overrun <= 0.
  - No bus transaction; the state machine is unaffected.
  - Never sets overrun.
- lcd_we=0: no effect. Strobes lasting several cycles count as one write per high cycle.

Test Plan (SETUP_CYC=2, EN_CYC=4, HOLD_CYC=2, EXEC_CYC=10, LONG_EXEC_CYC=40):
- Reset then idle → all outputs 0 and lcd_status=0x0. Pulse rst_n low mid-ENABLE → lcd_en and busy drop immediately, state returns to IDLE.
- Write 0x8000_0241 at cycle 0 → from cycle 1: lcd_rs=1, lcd_data=0x41, lcd_on=1, busy=1. lcd_en high on cycles 3–6 only. busy high for 18 cycles; lcd_status=0x4 afterwards.
- Write 0x8000_0001 (clear) → busy high for 48 cycles. Write 0x8000_0004 → busy high for 18 cycles (short wait).
- Normal write during EXEC → dropped, bus unchanged, lcd_status=0x7. Then write 0xC000_0000 → lcd_status=0x5 without disturbing the in-flight transaction.
- Write issued in the first cycle busy=0 → accepted, no overrun. Write issued in the last busy cycle → dropped, overrun=1.
- Control-only write 0x4000_0000 while idle → lcd_on=0, lcd_en never pulses, busy stays 0.

Source files
------------

// File: rtl/lcd_bus_driver.sv
// lcd_bus_driver
// Peripheral-side end of the LCD memory-mapped register. Each normal CPU
// store to the LCD window becomes one timed HD44780-style write cycle on
// the 8-bit LCD bus: setup, enable pulse, hold, then a command-execution
// wait. Software polls the busy bit in lcd_status instead of bit-banging
// the bus timing.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   lcd_we     one-cycle store strobe for the LCD address window
//   lcd_wdata  store data: [31] ON, [30] CTRL_ONLY, [9] RS, [7:0] DATA
//   lcd_status status word: [0] busy, [1] overrun, [2] on, [31:3] zero
//   lcd_data   LCD data bus
//   lcd_rs     register select
//   lcd_rw     read/write, always 0 (write-only bus)
//   lcd_en     enable strobe
//   lcd_on     LCD power
module lcd_bus_driver #(
  parameter int unsigned SETUP_CYC     = 3,
  parameter int unsigned EN_CYC        = 25,
  parameter int unsigned HOLD_CYC      = 3,
  parameter int unsigned EXEC_CYC      = 2500,
  parameter int unsigned LONG_EXEC_CYC = 82000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        lcd_we,
  input  logic [31:0] lcd_wdata,
  output logic [31:0] lcd_status,
  output logic [7:0]  lcd_data,
  output logic        lcd_rs,
  output logic        lcd_rw,
  output logic        lcd_en,
  output logic        lcd_on
);

  localparam int unsigned MAX_AB  = (SETUP_CYC > EN_CYC) ? SETUP_CYC : EN_CYC;
  localparam int unsigned MAX_ABC = (MAX_AB > HOLD_CYC) ? MAX_AB : HOLD_CYC;
  localparam int unsigned MAX_ABD = (MAX_ABC > EXEC_CYC) ? MAX_ABC : EXEC_CYC;
  localparam int unsigned MAX_CYC = (MAX_ABD > LONG_EXEC_CYC) ? MAX_ABD : LONG_EXEC_CYC;
  localparam int unsigned CW      = $clog2(MAX_CYC + 1);

  // Each phase loads (length - 1) and leaves when the counter reaches 0.
  localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] EN_LD    = CW'(EN_CYC - 1);
  localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] EXEC_LD  = CW'(EXEC_CYC - 1);
  localparam logic [CW-1:0] LONG_LD  = CW'(LONG_EXEC_CYC - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ENABLE,
    HOLD,
    EXEC
  } state_t;

  state_t        state, next_state;
  logic [CW-1:0] cnt, next_cnt;
  logic          overrun;
  logic          busy;
  logic          wr_normal, wr_ctrl, accept, long_cmd;
  logic          unused_wdata;

  assign wr_normal = lcd_we & ~lcd_wdata[30];
  assign wr_ctrl   = lcd_we &  lcd_wdata[30];
  assign accept    = wr_normal & (state == IDLE);

  // Clear (0x01) and home (0x02/0x03) need the long execution wait.
  assign long_cmd  = ~lcd_rs & (lcd_data[7:2] == 6'd0) & (lcd_data != 8'd0);

  assign unused_wdata = ^{lcd_wdata[29:10], lcd_wdata[8]};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          next_state = SETUP;
          next_cnt   = SETUP_LD;
        end
      end
      SETUP: begin
        if (cnt == '0) begin
          next_state = ENABLE;
          next_cnt   = EN_LD;
        end else begin
          next_cnt = cnt - 1'b1;
        end
      end
      ENABLE: begin
        if (cnt == '0) begin
          next_state = HOLD;
          next_cnt   = HOLD_LD;
        end else begin
          next_cnt = cnt - 1'b1;
        end
      end
      HOLD: begin
        if (cnt == '0) begin
          next_state = EXEC;
          next_cnt   = long_cmd ? LONG_LD : EXEC_LD;
        end else begin
          next_cnt = cnt - 1'b1;
        end
      end
      EXEC: begin
        if (cnt == '0) begin
          next_state = IDLE;
          next_cnt   = '0;
        end else begin
          next_cnt = cnt - 1'b1;
        end
      end
      default: begin
        next_state = IDLE;
        next_cnt   = '0;
      end
    endcase
  end

  // Output logic, decoded from the state register only
  always_comb begin
    lcd_en = (state == ENABLE);
    busy   = (state != IDLE);
  end

  // Bus latches, power and sticky overrun
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lcd_rs   <= 1'b0;
      lcd_data <= '0;
      lcd_on   <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (accept) begin
        lcd_rs   <= lcd_wdata[9];
        lcd_data <= lcd_wdata[7:0];
      end
      if (accept || wr_ctrl) begin
        lcd_on <= lcd_wdata[31];
      end
      if (wr_ctrl) begin
        overrun <= 1'b0;
      end else if (wr_normal && (state != IDLE)) begin
        overrun <= 1'b1;
      end
    end
  end

  assign lcd_rw     = 1'b0;
  assign lcd_status = {29'd0, lcd_on, overrun, busy};

endmodule
